// File: rtl/ysyx_23060187_rf_wb_arbiter.sv
// GPR write-back arbiter: round-robin sharing of the register-file write port
// between EXU (req0) and LSU (req1), plus a pending-write scoreboard for issue.
module ysyx_23060187_rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] chk_raddr1,
  input  logic [ADDR_WIDTH-1:0] chk_raddr2,
  output logic                  hazard
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  typedef enum logic {
    LAST_REQ0 = 1'b0,
    LAST_REQ1 = 1'b1
  } last_grant_e;

  last_grant_e           last_q, last_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NREGS-1:0]      busy_q, busy_d;

  logic                  grant0, grant1, xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    grant0 = req0_valid && (!req1_valid || (last_q == LAST_REQ1));
    grant1 = req1_valid && (!req0_valid || (last_q == LAST_REQ0));
    xfer   = grant0 || grant1;
    sel_addr = grant1 ? req1_addr : req0_addr;
    sel_data = grant1 ? req1_data : req0_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    wen_d   = xfer && (sel_addr != '0);
    waddr_d = xfer ? sel_addr : waddr_q;
    wdata_d = xfer ? sel_data : wdata_q;
    if (grant0)      last_d = LAST_REQ0;
    else if (grant1) last_d = LAST_REQ1;
    else             last_d = last_q;
  end

  assign issue_ready = (issue_rd == '0) || !busy_q[issue_rd];
  assign hazard = ((chk_raddr1 != '0) && busy_q[chk_raddr1]) ||
                  ((chk_raddr2 != '0) && busy_q[chk_raddr2]);

  // Clear applied before set so a same-edge set on the committing index wins.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) busy_d[waddr_q] = 1'b0;
    if (issue_valid && issue_ready && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= LAST_REQ1;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      last_q  <= last_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

endmodule

// File: tb/tb_ysyx_23060187_rf_wb_arbiter.sv
// Directed bench for the write-back arbiter: reset, single write, contention,
// scoreboard RAW/WAW, x0 handling and same-edge set/clear collision.
module tb_ysyx_23060187_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd, chk_raddr1, chk_raddr2;
  logic        hazard;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_23060187_rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .chk_raddr1(chk_raddr1), .chk_raddr2(chk_raddr2), .hazard(hazard)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  exp_addr [4];
    logic        exp_g0   [4];
    exp_addr = '{5'd1, 5'd11, 5'd2, 5'd12};
    exp_g0   = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    issue_valid = 1'b0; issue_rd = '0; chk_raddr1 = '0; chk_raddr2 = '0;
    #3;
    chk("rst_wen",   32'(rf_wen), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_hazard", 32'(hazard), 32'd0);
    step(); step();
    rst = 1'b0;

    // Single requester
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    chk("single_r0_ready", 32'(req0_ready), 32'd1);
    chk("single_r1_ready", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    chk("single_wen",   32'(rf_wen), 32'd1);
    chk("single_waddr", 32'(rf_waddr), 32'd5);
    chk("single_wdata", rf_wdata, 32'hDEADBEEF);
    step();
    chk("single_wen_off", 32'(rf_wen), 32'd0);

    // Mid-cycle reset while a write is on the port and a register is busy
    issue_valid = 1'b1; issue_rd = 5'd3;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
    chk_raddr1 = 5'd3;
    #1;
    chk("mid_issue_ready", 32'(issue_ready), 32'd1);
    chk("mid_r1_ready", 32'(req1_ready), 32'd1);
    step();
    issue_valid = 1'b0; req1_valid = 1'b0;
    chk("mid_wen", 32'(rf_wen), 32'd1);
    chk("mid_waddr", 32'(rf_waddr), 32'd6);
    chk("mid_hazard", 32'(hazard), 32'd1);
    chk("mid_waw_block", 32'(issue_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_wen", 32'(rf_wen), 32'd0);
    chk("async_rst_hazard", 32'(hazard), 32'd0);
    chk("async_rst_issue_ready", 32'(issue_ready), 32'd1);
    #2 rst = 1'b0;
    step();
    chk("post_rst_wen", 32'(rf_wen), 32'd0);
    chk_raddr1 = '0; issue_rd = '0;

    // Contention: grants must alternate starting with req0
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1000_0001;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h1000_000B;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont_g0_%0d", i), 32'(req0_ready), 32'(exp_g0[i]));
      chk($sformatf("cont_g1_%0d", i), 32'(req1_ready), 32'(!exp_g0[i]));
      step();
      chk($sformatf("cont_wen_%0d", i), 32'(rf_wen), 32'd1);
      chk($sformatf("cont_waddr_%0d", i), 32'(rf_waddr), 32'(exp_addr[i]));
      chk($sformatf("cont_wdata_%0d", i), rf_wdata, 32'h1000_0000 | 32'(exp_addr[i]));
      if (exp_g0[i]) begin
        req0_addr = req0_addr + 5'd1; req0_data = 32'h1000_0000 | 32'(req0_addr);
      end else begin
        req1_addr = req1_addr + 5'd1; req1_data = 32'h1000_0000 | 32'(req1_addr);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("cont_idle_wen", 32'(rf_wen), 32'd0);

    // Scoreboard RAW / WAW
    issue_valid = 1'b1; issue_rd = 5'd7; chk_raddr1 = 5'd7;
    #1;
    chk("raw_issue_ready", 32'(issue_ready), 32'd1);
    chk("raw_hazard_before", 32'(hazard), 32'd0);
    step();
    issue_valid = 1'b0;
    chk("raw_hazard_set", 32'(hazard), 32'd1);
    chk("waw_issue_blocked", 32'(issue_ready), 32'd0);
    chk_raddr1 = '0; chk_raddr2 = 5'd7;
    #1;
    chk("raw_hazard_src2", 32'(hazard), 32'd1);
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
    #1;
    chk("raw_r1_ready", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    chk("raw_wb_wen", 32'(rf_wen), 32'd1);
    chk("raw_hazard_during_wb", 32'(hazard), 32'd1);
    step();
    chk("raw_hazard_cleared", 32'(hazard), 32'd0);
    chk("raw_issue_ready_again", 32'(issue_ready), 32'd1);

    // x0 handling
    chk_raddr2 = '0;
    req0_valid = 1'b1; req0_addr = '0; req0_data = 32'h1234;
    issue_valid = 1'b1; issue_rd = '0;
    #1;
    chk("x0_r0_ready", 32'(req0_ready), 32'd1);
    chk("x0_issue_ready", 32'(issue_ready), 32'd1);
    step();
    req0_valid = 1'b0; issue_valid = 1'b0;
    chk("x0_wen", 32'(rf_wen), 32'd0);
    chk("x0_hazard", 32'(hazard), 32'd0);
    chk("x0_issue_ready_after", 32'(issue_ready), 32'd1);

    // Same-edge set and clear of register 9: set wins
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
    step();
    req0_valid = 1'b0;
    chk("coll_wen", 32'(rf_wen), 32'd1);
    chk("coll_waddr", 32'(rf_waddr), 32'd9);
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    chk("coll_issue_ready", 32'(issue_ready), 32'd1);
    step();
    issue_valid = 1'b0; chk_raddr1 = 5'd9;
    #1;
    chk("coll_busy_hazard", 32'(hazard), 32'd1);
    chk("coll_busy_block", 32'(issue_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
